exec_mem_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register of the 64-bit 5-stage RISC-V pipeline. It resolves data hazards by forwarding from EX/MEM and MEM/WB and selects register or immediate for operand B. It computes the ALU result, zero flag and branch target, and latches these with the pass-through control bits into the EX/MEM register feeding the memory stage.

---
 rtl/exec_mem_stage.sv | 133 +++++++++++++
 tb/tb_exec_mem_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_stage.sv
// Execute stage plus EX/MEM pipeline register: forwarding, ALU, zero flag, branch target.
// Define EXEC_FORWARDING_EN to enable EX/MEM and MEM/WB forwarding; otherwise operands come straight from ID/EX.
module exec_mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      id_ex_rs1,
  input  logic [4:0]      id_ex_rs2,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            alusrc_in,
  input  logic [3:0]      alu_ctrl_in,
  input  logic [4:0]      write_reg_in,
  input  logic            branch_in,
  input  logic            memwrite_in,
  input  logic            memread_in,
  input  logic            memtoreg_in,
  input  logic            regwrite_in,
  input  logic            flush_in,
  input  logic [4:0]      mem_wb_rd,
  input  logic            mem_wb_regwrite,
  input  logic [XLEN-1:0] wb_data,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic [XLEN-1:0] pc_out,
  output logic            zero_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] read_data2_out,
  output logic [4:0]      write_reg_out,
  output logic            branch_out,
  output logic            memwrite_out,
  output logic            memread_out,
  output logic            memtoreg_out,
  output logic            regwrite_out
);

  logic [XLEN-1:0] pc_q, alu_q, rd2_q;
  logic            zero_q;
  logic [4:0]      write_reg_q, write_reg_d;
  logic [4:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, target;

`ifdef EXEC_FORWARDING_EN
  // EX/MEM is checked first so the youngest producer wins; x0 never forwards.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (ctrl_q[0] && (write_reg_q != 5'd0) && (write_reg_q == id_ex_rs1))
      forward_a = 2'b10;
    else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs1))
      forward_a = 2'b01;
    if (ctrl_q[0] && (write_reg_q != 5'd0) && (write_reg_q == id_ex_rs2))
      forward_b = 2'b10;
    else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs2))
      forward_b = 2'b01;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{id_ex_rs1, id_ex_rs2, mem_wb_rd, mem_wb_regwrite};
  assign forward_a  = 2'b00;
  assign forward_b  = 2'b00;
`endif

  always_comb begin
    case (forward_a)
      2'b01:   fwd_a = wb_data;
      2'b10:   fwd_a = alu_q;
      default: fwd_a = rd1_in;
    endcase
    case (forward_b)
      2'b01:   fwd_b = wb_data;
      2'b10:   fwd_b = alu_q;
      default: fwd_b = rd2_in;
    endcase
  end

  assign op_b   = alusrc_in ? imm_in : fwd_b;
  assign target = pc_in + (imm_in << 1);

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_in)
      4'b0000: alu_res = fwd_a & op_b;
      4'b0001: alu_res = fwd_a | op_b;
      4'b0010: alu_res = fwd_a + op_b;
      4'b0011: alu_res = fwd_a ^ op_b;
      4'b0100: alu_res = fwd_a << op_b[5:0];
      4'b0101: alu_res = fwd_a >> op_b[5:0];
      4'b0110: alu_res = fwd_a - op_b;
      4'b0111: alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // A flush turns the slot into a bubble but the data fields still latch.
  always_comb begin
    ctrl_d      = flush_in ? 5'd0 : {branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in};
    write_reg_d = flush_in ? 5'd0 : write_reg_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= '0;
      alu_q       <= '0;
      rd2_q       <= '0;
      zero_q      <= 1'b0;
      write_reg_q <= '0;
      ctrl_q      <= '0;
    end else begin
      pc_q        <= target;
      alu_q       <= alu_res;
      rd2_q       <= fwd_b;
      zero_q      <= (alu_res == '0);
      write_reg_q <= write_reg_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign pc_out         = pc_q;
  assign zero_out       = zero_q;
  assign alu_result_out = alu_q;
  assign read_data2_out = rd2_q;
  assign write_reg_out  = write_reg_q;
  assign branch_out     = ctrl_q[4];
  assign memwrite_out   = ctrl_q[3];
  assign memread_out    = ctrl_q[2];
  assign memtoreg_out   = ctrl_q[1];
  assign regwrite_out   = ctrl_q[0];

endmodule

// File: tb/tb_exec_mem_stage.sv
// Directed self-checking bench for exec_mem_stage; expectations follow EXEC_FORWARDING_EN.
module tb_exec_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  idExRs1, idExRs2, writeRegIn, memWbRd;
  logic [63:0] rd1In, rd2In, immIn, pcIn, wbData;
  logic        alusrcIn, branchIn, memwriteIn, memreadIn, memtoregIn, regwriteIn, flushIn, memWbRegwrite;
  logic [3:0]  aluCtrlIn;
  logic [1:0]  forwardA, forwardB;
  logic [63:0] pcOut, aluResultOut, readData2Out;
  logic        zeroOut, branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut;
  logic [4:0]  writeRegOut;

  int checkCount = 0;
  int passCount  = 0;

  exec_mem_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .id_ex_rs1(idExRs1), .id_ex_rs2(idExRs2),
    .rd1_in(rd1In), .rd2_in(rd2In), .imm_in(immIn), .pc_in(pcIn),
    .alusrc_in(alusrcIn), .alu_ctrl_in(aluCtrlIn), .write_reg_in(writeRegIn),
    .branch_in(branchIn), .memwrite_in(memwriteIn), .memread_in(memreadIn),
    .memtoreg_in(memtoregIn), .regwrite_in(regwriteIn), .flush_in(flushIn),
    .mem_wb_rd(memWbRd), .mem_wb_regwrite(memWbRegwrite), .wb_data(wbData),
    .forward_a(forwardA), .forward_b(forwardB),
    .pc_out(pcOut), .zero_out(zeroOut), .alu_result_out(aluResultOut),
    .read_data2_out(readData2Out), .write_reg_out(writeRegOut),
    .branch_out(branchOut), .memwrite_out(memwriteOut), .memread_out(memreadOut),
    .memtoreg_out(memtoregOut), .regwrite_out(regwriteOut)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge, so outputs are sampled well clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    idExRs1 = 0; idExRs2 = 0; writeRegIn = 0; memWbRd = 0;
    rd1In = 0; rd2In = 0; immIn = 0; pcIn = 0; wbData = 0;
    alusrcIn = 0; branchIn = 0; memwriteIn = 0; memreadIn = 0; memtoregIn = 0;
    regwriteIn = 0; flushIn = 0; memWbRegwrite = 0; aluCtrlIn = 4'b0010;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clearInputs();
    #3;
    checkCount++; if (aluResultOut !== 64'd0) $display("[TB] FAIL reset_alu got %h exp 0", aluResultOut); else passCount++;
    checkCount++; if ({branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut, zeroOut} !== 6'd0)
      $display("[TB] FAIL reset_ctrl got %b exp 000000", {branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut, zeroOut}); else passCount++;
    tick();
    rst = 1'b1;
    rd1In = 64'd3; immIn = 64'd4; alusrcIn = 1; pcIn = 64'h10; branchIn = 1; regwriteIn = 1; writeRegIn = 5'd9;
    memreadIn = 1; memtoregIn = 1;
    tick();
    checkCount++; if (aluResultOut !== 64'd7) $display("[TB] FAIL pre_reset_alu got %h exp 7", aluResultOut); else passCount++;
    #2 rst = 1'b0;
    #1;
    checkCount++; if ({pcOut, aluResultOut, readData2Out} !== 192'd0)
      $display("[TB] FAIL async_reset_data got %h/%h/%h exp 0", pcOut, aluResultOut, readData2Out); else passCount++;
    checkCount++; if ({writeRegOut, branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut, zeroOut} !== 11'd0)
      $display("[TB] FAIL async_reset_ctrl got %h exp 0", {writeRegOut, branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut, zeroOut}); else passCount++;
    tick();
    checkCount++; if (aluResultOut !== 64'd0 || regwriteOut !== 1'b0)
      $display("[TB] FAIL reset_held got %h/%b exp 0/0", aluResultOut, regwriteOut); else passCount++;
    rst = 1'b1;
  endtask

  task automatic test_add_imm();
    clearInputs();
    rd1In = 64'd10; rd2In = 64'd99; alusrcIn = 1; immIn = 64'd5; aluCtrlIn = 4'b0010; writeRegIn = 5'd1;
    tick();
    checkCount++; if (aluResultOut !== 64'd15) $display("[TB] FAIL add_imm_alu got %h exp f", aluResultOut); else passCount++;
    checkCount++; if (zeroOut !== 1'b0) $display("[TB] FAIL add_imm_zero got %b exp 0", zeroOut); else passCount++;
    checkCount++; if (readData2Out !== 64'd99) $display("[TB] FAIL add_imm_store got %h exp 63", readData2Out); else passCount++;
  endtask

  task automatic test_sub_branch();
    clearInputs();
    rd1In = 64'd12; rd2In = 64'd12; aluCtrlIn = 4'b0110; pcIn = 64'h40; immIn = 64'd8; branchIn = 1;
    tick();
    checkCount++; if (aluResultOut !== 64'd0) $display("[TB] FAIL sub_alu got %h exp 0", aluResultOut); else passCount++;
    checkCount++; if (zeroOut !== 1'b1) $display("[TB] FAIL sub_zero got %b exp 1", zeroOut); else passCount++;
    checkCount++; if (pcOut !== 64'h50) $display("[TB] FAIL branch_target got %h exp 50", pcOut); else passCount++;
    checkCount++; if (branchOut !== 1'b1) $display("[TB] FAIL branch_out got %b exp 1", branchOut); else passCount++;
  endtask

  task automatic test_alu_ops();
    logic [3:0]  codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b0110, 4'b1111};
    logic [63:0] aVals [8] = '{64'hF0F0, 64'hF0, 64'hFF, 64'h1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1234};
    logic [63:0] bVals [8] = '{64'hFF00, 64'h0F, 64'h0F, 64'd65, 64'd63, 64'h1, 64'h1, 64'h1};
    logic [63:0] exps  [8] = '{64'hF000, 64'hFF, 64'hF0, 64'h2, 64'h1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    for (int i = 0; i < 8; i++) begin
      clearInputs();
      aluCtrlIn = codes[i]; rd1In = aVals[i]; rd2In = bVals[i];
      tick();
      checkCount++; if (aluResultOut !== exps[i] || zeroOut !== (exps[i] == 64'd0))
        $display("[TB] FAIL alu_op_%b got %h/%b exp %h/%b", codes[i], aluResultOut, zeroOut, exps[i], exps[i] == 64'd0);
      else passCount++;
    end
  endtask

  task automatic test_ex_mem_forward();
    logic [1:0]  expFwd;
    logic [63:0] expRes;
`ifdef EXEC_FORWARDING_EN
    expFwd = 2'b10; expRes = 64'h20;
`else
    expFwd = 2'b00; expRes = 64'h1;
`endif
    clearInputs();
    rd1In = 64'h1F; aluCtrlIn = 4'b0010; writeRegIn = 5'd5; regwriteIn = 1;
    tick();
    clearInputs();
    idExRs1 = 5'd5; rd1In = 64'd0; rd2In = 64'd1; aluCtrlIn = 4'b0010;
    #1;
    checkCount++; if (forwardA !== expFwd) $display("[TB] FAIL exmem_fwd_a got %b exp %b", forwardA, expFwd); else passCount++;
    tick();
    checkCount++; if (aluResultOut !== expRes) $display("[TB] FAIL exmem_fwd_res got %h exp %h", aluResultOut, expRes); else passCount++;
  endtask

  task automatic test_priority_x0();
    logic [1:0]  expFwdA, expFwdB;
    logic [63:0] expRes, expStore;
`ifdef EXEC_FORWARDING_EN
    expFwdA = 2'b10; expRes = 64'h100; expFwdB = 2'b01; expStore = 64'd7;
`else
    expFwdA = 2'b00; expRes = 64'h3; expFwdB = 2'b00; expStore = 64'h55;
`endif
    clearInputs();
    rd1In = 64'h100; regwriteIn = 1; writeRegIn = 5'd5;
    tick();
    clearInputs();
    idExRs1 = 5'd5; memWbRd = 5'd5; memWbRegwrite = 1; wbData = 64'h999; rd1In = 64'h3;
    regwriteIn = 1; writeRegIn = 5'd0;
    #1;
    checkCount++; if (forwardA !== expFwdA) $display("[TB] FAIL prio_fwd_a got %b exp %b", forwardA, expFwdA); else passCount++;
    tick();
    checkCount++; if (aluResultOut !== expRes) $display("[TB] FAIL prio_res got %h exp %h", aluResultOut, expRes); else passCount++;
    clearInputs();
    idExRs1 = 5'd0; memWbRd = 5'd0; memWbRegwrite = 1; wbData = 64'h999; rd1In = 64'h11; rd2In = 64'h22;
    #1;
    checkCount++; if (forwardA !== 2'b00) $display("[TB] FAIL x0_fwd_a got %b exp 00", forwardA); else passCount++;
    tick();
    checkCount++; if (aluResultOut !== 64'h33) $display("[TB] FAIL x0_res got %h exp 33", aluResultOut); else passCount++;
    clearInputs();
    idExRs2 = 5'd6; memWbRd = 5'd6; memWbRegwrite = 1; wbData = 64'd7; rd2In = 64'h55;
    #1;
    checkCount++; if (forwardB !== expFwdB) $display("[TB] FAIL memwb_fwd_b got %b exp %b", forwardB, expFwdB); else passCount++;
    tick();
    checkCount++; if (readData2Out !== expStore) $display("[TB] FAIL memwb_store got %h exp %h", readData2Out, expStore); else passCount++;
  endtask

  task automatic test_flush_store();
    logic [1:0]  expFwdB;
    logic [63:0] expStore;
`ifdef EXEC_FORWARDING_EN
    expFwdB = 2'b10; expStore = 64'hAB;
`else
    expFwdB = 2'b00; expStore = 64'h12;
`endif
    clearInputs();
    rd1In = 64'd4; rd2In = 64'd5; memwriteIn = 1; regwriteIn = 1; branchIn = 1; writeRegIn = 5'd3; flushIn = 1;
    tick();
    checkCount++; if ({branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut} !== 5'd0 || writeRegOut !== 5'd0)
      $display("[TB] FAIL flush_ctrl got %b/%h exp 00000/0", {branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut}, writeRegOut); else passCount++;
    checkCount++; if (aluResultOut !== 64'd9) $display("[TB] FAIL flush_data got %h exp 9", aluResultOut); else passCount++;
    clearInputs();
    rd1In = 64'hAB; regwriteIn = 1; writeRegIn = 5'd7;
    tick();
    clearInputs();
    idExRs2 = 5'd7; rd2In = 64'h12; rd1In = 64'h100; alusrcIn = 1; immIn = 64'h10; memwriteIn = 1;
    #1;
    checkCount++; if (forwardB !== expFwdB) $display("[TB] FAIL store_fwd_b got %b exp %b", forwardB, expFwdB); else passCount++;
    tick();
    checkCount++; if (readData2Out !== expStore) $display("[TB] FAIL store_data got %h exp %h", readData2Out, expStore); else passCount++;
    checkCount++; if (aluResultOut !== 64'h110 || memwriteOut !== 1'b1)
      $display("[TB] FAIL store_addr got %h/%b exp 110/1", aluResultOut, memwriteOut); else passCount++;
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_sub_branch();
    test_alu_ops();
    test_ex_mem_forward();
    test_priority_x0();
    test_flush_store();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
